// File: rtl/vec_register_file_v2.sv
// Vector register file: masked lane writes, two combinational read ports with
// write bypass, a pending-producer scoreboard and a sequenced bulk clear.
//
// state | meaning
// IDLE  | normal operation: writes, reserves and bypass are active
// CLEAR | zeroing one register per cycle; requests are dropped
module vec_register_file_v2 #(
  parameter int registerSize     = 8,
  parameter int registerQuantity = 8,
  parameter int selectionBits    = 3,
  parameter int vectorSize       = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    regWrEn,
  input  logic [selectionBits-1:0]                regToWrite,
  input  logic [vectorSize-1:0]                   regWrMask,
  input  logic [vectorSize-1:0][registerSize-1:0] regWriteData,
  input  logic [selectionBits-1:0]                rSel1,
  input  logic [selectionBits-1:0]                rSel2,
  output logic [vectorSize-1:0][registerSize-1:0] reg1Out,
  output logic [vectorSize-1:0][registerSize-1:0] reg2Out,
  input  logic                                    reserveEn,
  input  logic [selectionBits-1:0]                reserveSel,
  output logic                                    busy1,
  output logic                                    busy2,
  input  logic                                    clrReq,
  output logic                                    clrBusy,
  output logic                                    regWrReady,
  output logic                                    clrDone
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;

  state_t                      state;
  state_t                      state_next;
  logic [selectionBits-1:0]    counter;
  logic [registerQuantity-1:0] pending;
  logic [registerQuantity-1:0] pending_next;
  logic                        done_q;
  vec_t                        regs [registerQuantity];

  logic in_idle;
  logic wr_accept;
  logic rsv_accept;
  logic clr_start;
  logic cnt_last;

  assign in_idle    = (state == IDLE);
  assign wr_accept  = regWrEn && in_idle;
  assign rsv_accept = reserveEn && in_idle;
  assign clr_start  = clrReq && in_idle;
  assign cnt_last   = (counter == selectionBits'(registerQuantity - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clrReq) state_next = CLEAR;
      CLEAR:   if (cnt_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reserve is applied after the write-clear so a same-cycle reserve wins;
  // starting a clear wipes the whole scoreboard.
  always_comb begin
    pending_next = pending;
    if (wr_accept) pending_next[regToWrite] = 1'b0;
    if (rsv_accept) pending_next[reserveSel] = 1'b1;
    if (clr_start) pending_next = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      pending <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < registerQuantity; i++) regs[i] <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      done_q  <= (state == CLEAR) && cnt_last;
      if (state == CLEAR) begin
        regs[counter] <= '0;
        counter       <= counter + selectionBits'(1);
      end else begin
        if (wr_accept) begin
          for (int j = 0; j < vectorSize; j++)
            if (regWrMask[j]) regs[regToWrite][j] <= regWriteData[j];
        end
        if (clr_start) counter <= '0;
      end
    end
  end

  // Bypass only in IDLE so that reads during a clear show stored contents.
  always_comb begin
    reg1Out = regs[rSel1];
    if (wr_accept && (rSel1 == regToWrite)) begin
      for (int j = 0; j < vectorSize; j++)
        if (regWrMask[j]) reg1Out[j] = regWriteData[j];
    end
  end

  always_comb begin
    reg2Out = regs[rSel2];
    if (wr_accept && (rSel2 == regToWrite)) begin
      for (int j = 0; j < vectorSize; j++)
        if (regWrMask[j]) reg2Out[j] = regWriteData[j];
    end
  end

  assign busy1      = pending[rSel1];
  assign busy2      = pending[rSel2];
  assign clrBusy    = (state == CLEAR);
  assign regWrReady = (state != CLEAR);
  assign clrDone    = done_q;

endmodule

// File: tb/tb_vec_register_file_v2.sv
// Bench for vec_register_file_v2: directed vector table, clear/reset
// sequences and randomized traffic against an array-based reference model.
module tb_vec_register_file_v2;
  localparam int RS = 8;
  localparam int RQ = 8;
  localparam int SB = 3;
  localparam int VS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   regWrEn;
  logic [SB-1:0]          regToWrite;
  logic [VS-1:0]          regWrMask;
  logic [VS-1:0][RS-1:0]  regWriteData;
  logic [SB-1:0]          rSel1, rSel2;
  logic [VS-1:0][RS-1:0]  reg1Out, reg2Out;
  logic                   reserveEn;
  logic [SB-1:0]          reserveSel;
  logic                   busy1, busy2;
  logic                   clrReq;
  logic                   clrBusy, regWrReady, clrDone;

  vec_register_file_v2 #(
    .registerSize(RS), .registerQuantity(RQ), .selectionBits(SB), .vectorSize(VS)
  ) dut (
    .clk(clk), .reset(reset), .regWrEn(regWrEn), .regToWrite(regToWrite),
    .regWrMask(regWrMask), .regWriteData(regWriteData), .rSel1(rSel1), .rSel2(rSel2),
    .reg1Out(reg1Out), .reg2Out(reg2Out), .reserveEn(reserveEn), .reserveSel(reserveSel),
    .busy1(busy1), .busy2(busy2), .clrReq(clrReq), .clrBusy(clrBusy),
    .regWrReady(regWrReady), .clrDone(clrDone)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays plus a count of clear cycles still to run.
  logic [RS-1:0] m_mem [RQ][VS];
  bit            m_pend [RQ];
  int            m_clr_left;
  int            m_clr_idx;
  bit            m_done;

  function automatic logic [VS*RS-1:0] m_read(input int sel);
    logic [VS*RS-1:0] r;
    logic [RS-1:0]    lane;
    for (int j = 0; j < VS; j++) begin
      lane = m_mem[sel][j];
      if (m_clr_left == 0 && regWrEn && sel == int'(regToWrite) && regWrMask[j])
        lane = regWriteData[j];
      r[j*RS +: RS] = lane;
    end
    return r;
  endfunction

  task automatic check_model();
    chk("reg1Out", reg1Out, m_read(int'(rSel1)));
    chk("reg2Out", reg2Out, m_read(int'(rSel2)));
    chk("busy1", busy1, m_pend[rSel1]);
    chk("busy2", busy2, m_pend[rSel2]);
    chk("clrBusy", clrBusy, m_clr_left > 0);
    chk("regWrReady", regWrReady, m_clr_left == 0);
    chk("clrDone", clrDone, m_done);
  endtask

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < RQ; i++) begin
        m_pend[i] = 0;
        for (int j = 0; j < VS; j++) m_mem[i][j] = '0;
      end
      m_clr_left = 0;
      m_clr_idx  = 0;
      m_done     = 0;
    end else if (m_clr_left > 0) begin
      for (int j = 0; j < VS; j++) m_mem[m_clr_idx][j] = '0;
      m_clr_idx++;
      m_clr_left--;
      m_done = (m_clr_left == 0);
    end else begin
      m_done = 0;
      if (regWrEn) begin
        for (int j = 0; j < VS; j++)
          if (regWrMask[j]) m_mem[regToWrite][j] = regWriteData[j];
        m_pend[regToWrite] = 0;
      end
      if (reserveEn) m_pend[reserveSel] = 1;
      if (clrReq) begin
        for (int i = 0; i < RQ; i++) m_pend[i] = 0;
        m_clr_left = RQ;
        m_clr_idx  = 0;
      end
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
    check_model();
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    to_negedge();
    finish_cycle();
  endtask

  task automatic idle_inputs();
    reset = 0; regWrEn = 0; regToWrite = '0; regWrMask = '0; regWriteData = '0;
    rSel1 = '0; rSel2 = '0; reserveEn = 0; reserveSel = '0; clrReq = 0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < RQ; i++) begin
      idle_inputs();
      regWrEn = 1; regToWrite = SB'(i); regWrMask = '1;
      regWriteData = {VS{RS'(8'h10 + i)}};
      cycle();
    end
    idle_inputs();
  endtask

  typedef struct {
    bit            we;
    int            wr;
    logic [VS-1:0] mask;
    logic [31:0]   data;
    int            s1;
    int            s2;
    bit            rv;
    int            rs;
    logic [31:0]   e1;
    logic [31:0]   e2;
    bit            eb1;
    bit            eb2;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1, 2, 4'hF, 32'h11111111, 2, 0, 0, 0, 32'h11111111, 32'h0, 0, 0};
    tbl[1]  = '{1, 2, 4'h5, 32'hAAAAAAAA, 2, 2, 0, 0, 32'h11AA11AA, 32'h11AA11AA, 0, 0};
    tbl[2]  = '{0, 0, 4'h0, 32'h0, 2, 0, 0, 0, 32'h11AA11AA, 32'h0, 0, 0};
    tbl[3]  = '{1, 5, 4'hF, 32'h01020304, 5, 5, 0, 0, 32'h01020304, 32'h01020304, 0, 0};
    tbl[4]  = '{0, 0, 4'h0, 32'h0, 5, 2, 0, 0, 32'h01020304, 32'h11AA11AA, 0, 0};
    tbl[5]  = '{0, 0, 4'h0, 32'h0, 3, 0, 1, 3, 32'h0, 32'h0, 0, 0};
    tbl[6]  = '{0, 0, 4'h0, 32'h0, 3, 0, 0, 0, 32'h0, 32'h0, 1, 0};
    tbl[7]  = '{1, 3, 4'h1, 32'h00000055, 3, 3, 1, 3, 32'h55, 32'h55, 1, 1};
    tbl[8]  = '{0, 0, 4'h0, 32'h0, 3, 3, 0, 0, 32'h55, 32'h55, 1, 1};
    tbl[9]  = '{1, 3, 4'h0, 32'hFFFFFFFF, 3, 2, 0, 0, 32'h55, 32'h11AA11AA, 1, 0};
    tbl[10] = '{0, 0, 4'h0, 32'h0, 3, 5, 0, 0, 32'h55, 32'h01020304, 0, 0};
    tbl[11] = '{0, 0, 4'h0, 32'h0, 0, 7, 1, 7, 32'h0, 32'h0, 0, 0};
    tbl[12] = '{0, 0, 4'h0, 32'h0, 2, 7, 0, 0, 32'h11AA11AA, 32'h0, 0, 1};

    idle_inputs();
    reset = 1;
    repeat (2) finish_cycle();
    reset = 0;

    // post-reset state
    @(negedge clk);
    chk("rst_reg1Out", reg1Out, '0);
    chk("rst_reg2Out", reg2Out, '0);
    chk("rst_busy", {busy1, busy2}, 2'b00);
    chk("rst_clrBusy", clrBusy, 1'b0);
    chk("rst_regWrReady", regWrReady, 1'b1);
    chk("rst_clrDone", clrDone, 1'b0);
    check_model();
    finish_cycle();

    // directed vector table
    for (int k = 0; k < 13; k++) begin
      idle_inputs();
      regWrEn = tbl[k].we; regToWrite = SB'(tbl[k].wr); regWrMask = tbl[k].mask;
      regWriteData = tbl[k].data; rSel1 = SB'(tbl[k].s1); rSel2 = SB'(tbl[k].s2);
      reserveEn = tbl[k].rv; reserveSel = SB'(tbl[k].rs);
      to_negedge();
      chk($sformatf("tbl%0d_reg1Out", k), reg1Out, tbl[k].e1);
      chk($sformatf("tbl%0d_reg2Out", k), reg2Out, tbl[k].e2);
      chk($sformatf("tbl%0d_busy1", k), busy1, tbl[k].eb1);
      chk($sformatf("tbl%0d_busy2", k), busy2, tbl[k].eb2);
      finish_cycle();
    end

    // bulk clear with a dropped write mid-clear
    fill_all();
    clrReq = 1;
    cycle();
    clrReq = 0;
    for (int k = 1; k <= RQ; k++) begin
      idle_inputs();
      if (k == 3) begin
        regWrEn = 1; regToWrite = '0; regWrMask = '1; regWriteData = 32'hDEADBEEF;
        reserveEn = 1; reserveSel = 3'd6; clrReq = 1;
      end
      to_negedge();
      chk($sformatf("clr_busy_c%0d", k), clrBusy, 1'b1);
      chk($sformatf("clr_ready_c%0d", k), regWrReady, 1'b0);
      chk($sformatf("clr_done_c%0d", k), clrDone, 1'b0);
      finish_cycle();
    end
    idle_inputs();
    to_negedge();
    chk("clr_done_pulse", clrDone, 1'b1);
    chk("clr_busy_end", clrBusy, 1'b0);
    finish_cycle();
    for (int i = 0; i < RQ; i++) begin
      rSel1 = SB'(i); rSel2 = 3'd6;
      to_negedge();
      chk($sformatf("clr_zero_r%0d", i), reg1Out, '0);
      chk("clr_drop_reserve", busy2, 1'b0);
      chk("clr_done_once", clrDone, 1'b0);
      finish_cycle();
    end

    // reset in the middle of a clear
    fill_all();
    clrReq = 1;
    cycle();
    clrReq = 0;
    for (int k = 1; k <= 3; k++) cycle();
    reset = 1;
    finish_cycle();
    reset = 0;
    for (int k = 0; k < RQ + 4; k++) begin
      rSel1 = SB'(k % RQ); rSel2 = SB'((k + 3) % RQ);
      to_negedge();
      chk("rstclr_busy", clrBusy, 1'b0);
      chk("rstclr_done", clrDone, 1'b0);
      chk("rstclr_reg1", reg1Out, '0);
      finish_cycle();
    end

    // clrReq held high: clears back to back, each restart sampled in IDLE
    fill_all();
    clrReq = 1;
    for (int k = 0; k < 3 * (RQ + 1) + 2; k++) begin
      rSel1 = SB'(k % RQ);
      regWrEn = 1; regToWrite = SB'(k % RQ); regWrMask = '1; regWriteData = 32'h5A5A5A5A;
      cycle();
    end
    idle_inputs();
    repeat (2) cycle();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 499) == 0);
      regWrEn      = $urandom_range(0, 1);
      regToWrite   = SB'($urandom);
      regWrMask    = VS'($urandom);
      regWriteData = $urandom;
      rSel1        = ($urandom_range(0, 1) == 0) ? regToWrite : SB'($urandom);
      rSel2        = ($urandom_range(0, 2) == 0) ? regToWrite : SB'($urandom);
      reserveEn    = ($urandom_range(0, 3) == 0);
      reserveSel   = ($urandom_range(0, 2) == 0) ? regToWrite : SB'($urandom);
      clrReq       = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vec_register_file_v2.md
VEC_REGISTER_FILE_V2 -- requirements
Module: vec_register_file_v2

Interface
REQ-001 The block SHALL provide parameter registerSize, default 8, lane width in bits.
REQ-002 The block SHALL provide parameter registerQuantity, default 8, number of vector registers.
REQ-003 The block SHALL provide parameter selectionBits, default 3, register select width, with 2**selectionBits == registerQuantity.
REQ-004 The block SHALL provide parameter vectorSize, default 4, lanes per register.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 regWrEn  input  1  write request.
REQ-008 regToWrite  input  selectionBits  write register select.
REQ-009 regWrMask  input  vectorSize  per-lane write enable; bit j gates lane j.
REQ-010 regWriteData  input  vectorSize x registerSize  write data, lane j = element j.
REQ-011 rSel1, rSel2  input  selectionBits each  read selects.
REQ-012 reg1Out, reg2Out  output  vectorSize x registerSize each  read data.
REQ-013 reserveEn  input  1, reserveSel  input  selectionBits  mark a register pending (in-flight producer).
REQ-014 busy1, busy2  output  1 each  pending bit of rSel1 / rSel2.
REQ-015 clrReq  input  1  request bulk zeroing of all registers.
REQ-016 clrBusy  output  1  clear in progress; regWrReady  output  1  equals NOT clrBusy.
REQ-017 clrDone  output  1  one-cycle pulse on clear completion.

Function
REQ-018 Storage SHALL be registerQuantity x vectorSize lanes of registerSize bits, clocked only by clk (no gated clocks).
REQ-019 Write: when regWrEn=1 and regWrReady=1, lane j of register regToWrite SHALL update at the edge iff regWrMask[j]=1; unmasked lanes hold.
REQ-020 Write with regWrMask all zero SHALL change no data but SHALL still clear the pending bit of regToWrite.
REQ-021 Reads SHALL be combinational; reg1Out/reg2Out = stored contents of rSel1/rSel2.
REQ-022 Bypass: in IDLE, if regWrEn=1 and rSelN == regToWrite, lane j of regNOut SHALL show regWriteData[j] where regWrMask[j]=1, stored lane otherwise.
REQ-023 Scoreboard: one pending bit per register; reserveEn=1 SHALL set bit reserveSel at the edge; an accepted write SHALL clear bit regToWrite at the edge.
REQ-024 Reserve and accepted write to the same register in one cycle: data SHALL be committed, pending bit SHALL end set.
REQ-025 busyN SHALL be combinational pending[rSelN], reflecting state before the current edge (no bypass).
REQ-026 FSM states IDLE and CLEAR; reset state IDLE.
REQ-027 IDLE -> CLEAR when clrReq=1; a write or reserve in that same cycle SHALL be accepted normally; at the transition all pending bits SHALL be cleared, counter loaded with 0.
REQ-028 In CLEAR, each cycle SHALL zero all lanes of register[counter] and increment counter; after register registerQuantity-1 is zeroed, state SHALL return to IDLE.
REQ-029 Clear SHALL take exactly registerQuantity cycles: clrReq sampled at edge t, clrBusy=1 during cycles t+1..t+registerQuantity, clrDone=1 during cycle t+registerQuantity+1 only.
REQ-030 In CLEAR, regWrEn, reserveEn and clrReq SHALL be ignored (dropped, not queued); bypass disabled; reads return stored contents.
REQ-031 clrReq held high continuously SHALL start a new clear only when sampled in IDLE.

Reset
REQ-032 reset=1 at an edge SHALL zero all register lanes, all pending bits, counter, and force state IDLE, taking priority over every other input, including mid-clear.
REQ-033 Post-reset outputs: reg1Out=reg2Out=0, busy1=busy2=0, clrBusy=0, regWrReady=1, clrDone=0.

Verification
REQ-034 Masked write: reg 2 all lanes 0x11, then write 0xAA.. with mask 4'b0101 -> reg 2 reads {0x11,0xAA,0x11,0xAA} (lane3..0).
REQ-035 Bypass: rSel1=5, write reg 5 data {1,2,3,4} mask 4'b1111 same cycle -> reg1Out={1,2,3,4} combinationally before the edge; stored after.
REQ-036 Scoreboard: reserve reg 3 -> busy1=1 with rSel1=3 next cycle; reserve and write reg 3 together -> busy stays 1; write alone -> busy1=0 next cycle.
REQ-037 Clear: fill all 8 regs nonzero, pulse clrReq at t -> clrBusy high cycles t+1..t+8, write attempted at t+3 dropped, clrDone at t+9, all regs read 0.
REQ-038 Reset mid-clear: assert reset at t+4 -> next cycle state IDLE, all regs 0, clrBusy=0, clrDone never pulses.
